vga_sprite_window: RTL
======================

VGA_SPRITE_WINDOW -- requirements
Module: vga_sprite_window

Interface
- REQ-001: Parameter Size, default 16, sprite edge length in pixels (square sprite).
- REQ-002: Parameter HMAX, default 640, visible columns.
- REQ-003: Parameter VMAX, default 480, visible rows.
- REQ-004: clk  input  1  single system/pixel clock; all state SHALL update on its rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: PixX  input  10  current screen column from the timing generator.
- REQ-007: PixY  input  10  current screen row from the timing generator.
- REQ-008: Active  input  1  high while (PixX, PixY) is in the visible area.
- REQ-009: FrameStart  input  1  one-cycle pulse at start of vertical blank.
- REQ-010: PosX  input  10  requested sprite top-left column.
- REQ-011: PosY  input  10  requested sprite top-left row.
- REQ-012: PosValid  input  1  request carries a valid position.
- REQ-013: PosReady  output  1  block can accept a position.
- REQ-014: Row  output  10  sprite-local row; feeds the sprite memory address stage.
- REQ-015: Col  output  10  sprite-local column; feeds the sprite memory address stage.
- REQ-016: InSprite  output  1  registered pixel lies inside the sprite window.

Function
- REQ-017: The block SHALL hold the applied position in registers CurX/CurY and a captured request in PendX/PendY.
- REQ-018: FSM states: IDLE (no request held) and HELD (request captured, awaiting frame boundary).
- REQ-019: PosReady SHALL be 1 in IDLE and 0 in HELD; it is a Moore output with no dependence on PosValid.
- REQ-020: Transfer occurs when PosValid and PosReady are both 1 on a clock edge; Pend SHALL load the clamped request and the FSM SHALL go IDLE->HELD.
- REQ-021: Clamping: PendX = min(PosX, HMAX-Size), PendY = min(PosY, VMAX-Size).
- REQ-022: In HELD, on FrameStart=1, Cur SHALL load Pend and the FSM SHALL go HELD->IDLE in the same edge.
- REQ-023: FrameStart in IDLE SHALL have no effect.
- REQ-024: A transfer coinciding with FrameStart in IDLE SHALL enter HELD and apply only at the next FrameStart.
- REQ-025: Cur SHALL never change outside a FrameStart edge, so no frame shows a torn sprite.
- REQ-026: Window test (combinational hit): Active=1 and CurX <= PixX < CurX+Size and CurY <= PixY < CurY+Size; comparisons SHALL use 11-bit arithmetic to avoid overflow.
- REQ-027: Latency: exactly 1 cycle; InSprite, Row and Col SHALL be registered from the window test on the PixX/PixY/Active sampled at the same edge.
- REQ-028: On hit: Row = PixY-CurY and Col = PixX-CurX, each in range 0..Size-1, zero-extended to 10 bits.
- REQ-029: On miss: Row = 0, Col = 0 and InSprite = 0.
- REQ-030: The window test SHALL use the Cur values before any update made on the same edge.

Reset
- REQ-031: With reset=1 at a clock edge: FSM=IDLE; CurX=CurY=0; PendX=PendY=0; Row=0; Col=0; InSprite=0.
- REQ-032: PosReady SHALL be forced to 0 while reset is high and be 1 in the first cycle after release.
- REQ-033: Reset asserted in HELD SHALL discard the pending request without applying it.
- REQ-034: Reset SHALL override a simultaneous FrameStart or transfer.

Verification
- REQ-035: After reset, sweep PixX=0..20 at PixY=3 with Active=1 -> InSprite=1 one cycle later for PixX 0..15 only, with Col=PixX and Row=3.
- REQ-036: Drive PosX=100, PosY=50 with PosValid for 1 cycle, then pixel (105,52) before FrameStart -> InSprite=0; pulse FrameStart, then (105,52) -> InSprite=1, Row=2, Col=5.
- REQ-037: With HELD pending, hold PosValid with a new value (200,200) -> PosReady=0 and Pend unchanged; after FrameStart -> PosReady=1, the next transfer is accepted and applied at the following FrameStart.
- REQ-038: Request PosX=1023, PosY=1023, then FrameStart -> CurX=624, CurY=464; pixel (639,479) -> InSprite=1, Row=15, Col=15.
- REQ-039: Transfer in the same cycle as FrameStart -> position not applied; applied at the second FrameStart.
- REQ-040: Reset in HELD, then FrameStart -> Cur remains (0,0) and PosReady=1.
- REQ-041: Active=0 at a pixel inside the window -> InSprite=0, Row=0, Col=0.

Source files
------------

// File: rtl/vga_sprite_window_if.sv
// Bundles the pixel-timing, position-request and sprite-window signals of vga_sprite_window.
// The master drives the pixel and request inputs; the slave is the window block.
interface vga_sprite_window_if;
  logic [9:0] PixX;
  logic [9:0] PixY;
  logic       Active;
  logic       FrameStart;
  logic [9:0] PosX;
  logic [9:0] PosY;
  logic       PosValid;
  logic       PosReady;
  logic [9:0] Row;
  logic [9:0] Col;
  logic       InSprite;

  modport master (
    output PixX, PixY, Active, FrameStart, PosX, PosY, PosValid,
    input  PosReady, Row, Col, InSprite
  );

  modport slave (
    input  PixX, PixY, Active, FrameStart, PosX, PosY, PosValid,
    output PosReady, Row, Col, InSprite
  );
endinterface

// File: rtl/vga_sprite_window.sv
// Square sprite window: latches a clamped position request and applies it only at a frame
// boundary, then flags pixels inside the window one cycle later with sprite-local row/col.
module vga_sprite_window #(
  parameter int Size = 16,
  parameter int HMAX = 640,
  parameter int VMAX = 480
) (
  input  logic              clk,
  input  logic              reset,
  vga_sprite_window_if.slave bus
);

  localparam logic [9:0]  MAX_X  = 10'(HMAX - Size);
  localparam logic [9:0]  MAX_Y  = 10'(VMAX - Size);
  localparam logic [10:0] SIZE_W = 11'(Size);

  typedef enum logic {IDLE, HELD} state_t;

  state_t      state;
  logic        ready_q;
  logic [9:0]  cur_x;
  logic [9:0]  cur_y;
  logic [9:0]  pend_x;
  logic [9:0]  pend_y;
  logic        transfer;

  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        hit;
  logic [9:0]  row_p0;
  logic [9:0]  col_p0;

  logic        in_sprite_p1;
  logic [9:0]  row_p1;
  logic [9:0]  col_p1;

  // Keeps the whole sprite on screen: the top-left may not exceed limit.
  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] limit);
    return (v > limit) ? limit : v;
  endfunction

  // Ready is a pure function of state; reset masks it so nothing is accepted during reset.
  assign bus.PosReady = ready_q & ~reset;
  assign transfer     = bus.PosValid & bus.PosReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      cur_x   <= '0;
      cur_y   <= '0;
      pend_x  <= '0;
      pend_y  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            pend_x  <= clamp(bus.PosX, MAX_X);
            pend_y  <= clamp(bus.PosY, MAX_Y);
            state   <= HELD;
            ready_q <= 1'b0;
          end
        end
        HELD: begin
          if (bus.FrameStart) begin
            cur_x   <= pend_x;
            cur_y   <= pend_y;
            state   <= IDLE;
            ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Stage p0: combinational window test against the current (pre-update) position.
  assign x_end  = {1'b0, cur_x} + SIZE_W;
  assign y_end  = {1'b0, cur_y} + SIZE_W;
  assign hit    = bus.Active
                  && ({1'b0, bus.PixX} >= {1'b0, cur_x}) && ({1'b0, bus.PixX} < x_end)
                  && ({1'b0, bus.PixY} >= {1'b0, cur_y}) && ({1'b0, bus.PixY} < y_end);
  assign col_p0 = hit ? (bus.PixX - cur_x) : '0;
  assign row_p0 = hit ? (bus.PixY - cur_y) : '0;

  // Stage p1: registered window result, one cycle after the pixel was sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_sprite_p1 <= 1'b0;
      row_p1       <= '0;
      col_p1       <= '0;
    end else begin
      in_sprite_p1 <= hit;
      row_p1       <= row_p0;
      col_p1       <= col_p0;
    end
  end

  assign bus.InSprite = in_sprite_p1;
  assign bus.Row      = row_p1;
  assign bus.Col      = col_p1;

endmodule
